// File: rtl/wallace_mac_acc.sv
// Batch accumulator for Wallace-tree 4x4 products.
// Sums N_TERMS products, then holds the result until the consumer takes it.
module wallace_mac_acc #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             acc_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             w_prod_hs;
    logic             w_last;
    logic [ACC_W:0]   w_sum_ext;

    // Extra MSB captures the carry out for the sticky overflow bit.
    assign w_sum_ext = {1'b0, r_sum} + {{(ACC_W-7){1'b0}}, prod};
    assign w_last    = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        prod_ready  = 1'b0;
        acc_valid   = 1'b0;
        w_prod_hs   = 1'b0;
        unique case (r_state)
            ACCUM: begin
                prod_ready = 1'b1;
                w_prod_hs  = prod_valid;
                if (prod_valid && w_last)
                    w_state_nxt = HOLD;
            end
            HOLD: begin
                acc_valid = 1'b1;
                if (acc_ready)
                    w_state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ACCUM;
        else if (clear)
            r_state <= ACCUM;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else if (clear) begin
            r_sum    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_prod_hs) begin
            if (w_last) begin
                r_acc    <= w_sum_ext[ACC_W-1:0];
                r_ovf    <= r_sticky | w_sum_ext[ACC_W];
                r_sum    <= '0;
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_sum    <= w_sum_ext[ACC_W-1:0];
                r_cnt    <= r_cnt + CNT_W'(1);
                r_sticky <= r_sticky | w_sum_ext[ACC_W];
            end
        end
    end

    assign acc     = r_acc;
    assign acc_ovf = r_ovf;
    assign busy    = (r_cnt != '0);

endmodule

// File: tb/tb_wallace_mac_acc.sv
// Directed bench: default, 8-bit accumulator and single-term instances.
module tb_wallace_mac_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic [7:0] prod = '0;
    logic prod_valid = 1'b0;
    logic acc_ready = 1'b0;

    logic [7:0] c_prod = '0;
    logic c_valid = 1'b0;
    logic c_acc_ready = 1'b0;

    logic a_prdy, a_avld, a_ovf, a_busy;
    logic [9:0] a_acc;
    logic b_prdy, b_avld, b_ovf, b_busy;
    logic [7:0] b_acc;
    logic c_prdy, c_avld, c_ovf, c_busy;
    logic [9:0] c_acc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wallace_mac_acc #(.N_TERMS(4), .ACC_W(10)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod(prod), .prod_valid(prod_valid), .prod_ready(a_prdy),
        .acc(a_acc), .acc_valid(a_avld), .acc_ready(acc_ready),
        .acc_ovf(a_ovf), .busy(a_busy)
    );

    wallace_mac_acc #(.N_TERMS(4), .ACC_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod(prod), .prod_valid(prod_valid), .prod_ready(b_prdy),
        .acc(b_acc), .acc_valid(b_avld), .acc_ready(acc_ready),
        .acc_ovf(b_ovf), .busy(b_busy)
    );

    wallace_mac_acc #(.N_TERMS(1), .ACC_W(10)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod(c_prod), .prod_valid(c_valid), .prod_ready(c_prdy),
        .acc(c_acc), .acc_valid(c_avld), .acc_ready(c_acc_ready),
        .acc_ovf(c_ovf), .busy(c_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] p);
        prod = p;
        prod_valid = 1'b1;
        step();
        prod_valid = 1'b0;
    endtask

    task automatic release_acc();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_acc", int'(a_acc), 0);
        check("rst_valid", int'(a_avld), 0);
        check("rst_prdy", int'(a_prdy), 1);
        check("rst_busy", int'(a_busy), 0);
        check("rst_c_prdy", int'(c_prdy), 1);
        step();
        rst_n = 1'b1;
        step();

        // 225 x4 back-to-back: wraps only in the 8-bit instance
        push(8'd225);
        push(8'd225);
        check("busy_mid", int'(a_busy), 1);
        check("no_valid_mid", int'(a_avld), 0);
        push(8'd225);
        push(8'd225);
        check("a900_acc", int'(a_acc), 900);
        check("a900_ovf", int'(a_ovf), 0);
        check("a900_valid", int'(a_avld), 1);
        check("a900_prdy", int'(a_prdy), 0);
        check("a900_busy", int'(a_busy), 0);
        check("b132_acc", int'(b_acc), 132);
        check("b132_ovf", int'(b_ovf), 1);

        // stall in HOLD while upstream keeps offering a term
        prod = 8'd99;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_acc", int'(a_acc), 900);
            check("hold_valid", int'(a_avld), 1);
            check("hold_busy", int'(a_busy), 0);
        end
        prod_valid = 1'b0;
        release_acc();
        check("rel_valid", int'(a_avld), 0);
        check("rel_prdy", int'(a_prdy), 1);
        check("rel_busy", int'(a_busy), 0);

        push(8'd1);
        push(8'd2);
        push(8'd3);
        push(8'd4);
        check("a10_acc", int'(a_acc), 10);
        check("a10_ovf", int'(a_ovf), 0);
        check("b10_acc", int'(b_acc), 10);
        check("b10_ovf", int'(b_ovf), 0);
        release_acc();

        // clear discards partial sum and a coincident product
        push(8'd7);
        push(8'd9);
        check("pre_clr_busy", int'(a_busy), 1);
        clear = 1'b1;
        prod = 8'd50;
        prod_valid = 1'b1;
        step();
        clear = 1'b0;
        prod_valid = 1'b0;
        check("clr_busy", int'(a_busy), 0);
        check("clr_valid", int'(a_avld), 0);
        for (int i = 0; i < 4; i++) push(8'd1);
        check("clr_acc4", int'(a_acc), 4);
        check("clr_valid4", int'(a_avld), 1);
        release_acc();

        // asynchronous reset mid-batch
        push(8'd5);
        push(8'd6);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(a_busy), 0);
        check("arst_acc", int'(a_acc), 0);
        check("arst_prdy", int'(a_prdy), 1);
        #2;
        rst_n = 1'b1;
        step();
        push(8'd2);
        step();
        push(8'd2);
        step();
        step();
        push(8'd2);
        check("gap_no_valid", int'(a_avld), 0);
        push(8'd2);
        check("gap_acc8", int'(a_acc), 8);
        check("gap_valid", int'(a_avld), 1);

        // clear drops a held result
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("drop_valid", int'(a_avld), 0);
        check("drop_acc", int'(a_acc), 0);
        check("drop_prdy", int'(a_prdy), 1);

        // single-term batches
        c_prod = 8'd0;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        check("c0_acc", int'(c_acc), 0);
        check("c0_valid", int'(c_avld), 1);
        check("c0_prdy", int'(c_prdy), 0);
        c_acc_ready = 1'b1;
        step();
        c_acc_ready = 1'b0;
        check("c0_rel", int'(c_avld), 0);
        c_prod = 8'd255;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        check("c255_acc", int'(c_acc), 255);
        check("c255_valid", int'(c_avld), 1);
        check("c255_ovf", int'(c_ovf), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
